// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and latency counter width.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for MEM_LAT up to 7
    localparam int LAT_CW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } lsu_state_e;

    // Size code 2'b11 behaves as a word, so bit 1 alone marks word accesses
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (size[1])
            r = (off != 2'b00);
        else if (size == SZ_HALF)
            r = off[0];
        return r;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// CPU request/response and data-memory signals of the load/store unit.
// master = CPU/memory side, slave = the LSU itself.
interface mem_lsu_if #(
    parameter int AW = 32
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Big-endian lane logic: extracts and extends a load lane, and merges a store lane
// into the word that was read back.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_base,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte offset 0 is the most significant byte of the word
    always_comb begin
        w_byte = i_rword[31:24];
        case (i_off)
            2'd1:    w_byte = i_rword[23:16];
            2'd2:    w_byte = i_rword[15:8];
            2'd3:    w_byte = i_rword[7:0];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_off[1] ? i_rword[15:0] : i_rword[31:16];

        o_rdata = i_rword;
        if (i_size == SZ_BYTE)
            o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
        else if (i_size == SZ_HALF)
            o_rdata = {{16{i_signed & w_half[15]}}, w_half};

        o_merged = i_wdata;
        if (i_size == SZ_BYTE) begin
            o_merged = i_base;
            case (i_off)
                2'd1:    o_merged[23:16] = i_wdata[7:0];
                2'd2:    o_merged[15:8]  = i_wdata[7:0];
                2'd3:    o_merged[7:0]   = i_wdata[7:0];
                default: o_merged[31:24] = i_wdata[7:0];
            endcase
        end else if (i_size == SZ_HALF) begin
            o_merged = i_base;
            if (i_off[1])
                o_merged[15:0] = i_wdata[15:0];
            else
                o_merged[31:16] = i_wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for the word-wide big-endian data memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to reject misaligned halves/words.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_lsu_if.slave  bus
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_we;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rword;
    logic [31:0]       r_rdata;
    logic [LAT_CW-1:0] r_cnt;
    logic              w_accept;
    logic              w_misalign;
    logic [31:0]       w_extract;
    logic [31:0]       w_merged;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign bus.resp_err = (r_state == S_RESP) && r_err;
`else
    assign w_misalign = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Outputs decode from the state register only, so reset drops them without a clock
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = (r_state == S_IDLE);
        bus.mem_read   = (r_state == S_RD);
        bus.mem_write  = (r_state == S_WR);
        bus.resp_valid = (r_state == S_RESP);
        bus.resp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
        bus.mem_wdata  = (r_state == S_WR) ? w_merged : 32'h0;
        bus.mem_addr   = {r_addr[AW-1:2], 2'b00};
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)
                        w_next = S_RESP;
                    else if (bus.req_we && bus.req_size[1])
                        w_next = S_WR;
                    else
                        w_next = S_RD;
                end
            end
            S_RD: begin
                if (r_cnt == '0)
                    w_next = r_we ? S_WR : S_RESP;
            end
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SZ_BYTE;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rword  <= 32'h0;
            r_rdata  <= 32'h0;
            r_cnt    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_we     <= bus.req_we;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_rdata  <= 32'h0;
            r_cnt    <= LAT_CW'(MEM_LAT - 1);
`ifdef LSU_MISALIGN_TRAP_EN
            r_err    <= w_misalign;
`endif
        end else if (r_state == S_RD) begin
            // Memory data is only trusted on the final edge of the read window
            if (r_cnt == '0) begin
                r_rword <= bus.mem_rdata;
                if (!r_we)
                    r_rdata <= w_extract;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    lsu_lane u_lane (
        .i_size   (r_size),
        .i_off    (r_addr[1:0]),
        .i_signed (r_signed),
        .i_rword  (bus.mem_rdata),
        .i_base   (r_rword),
        .i_wdata  (r_wdata),
        .o_rdata  (w_extract),
        .o_merged (w_merged)
    );

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: two instances (MEM_LAT=1 and MEM_LAT=3), each with a
// byte-array big-endian data memory model.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_lsu_if #(.AW(32)) bus1 ();
    mem_lsu_if #(.AW(32)) bus3 ();

    mem_lsu #(.MEM_LAT(1), .AW(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mem_lsu #(.MEM_LAT(3), .AW(32)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic [7:0] mem1 [0:255];
    logic [7:0] mem3 [0:255];
    logic [7:0] a1;
    logic [7:0] a3;

    always #5 clk = ~clk;

    assign a1 = bus1.mem_addr[7:0];
    assign a3 = bus3.mem_addr[7:0];
    assign bus1.mem_rdata = {mem1[a1], mem1[a1 + 8'd1], mem1[a1 + 8'd2], mem1[a1 + 8'd3]};
    assign bus3.mem_rdata = {mem3[a3], mem3[a3 + 8'd1], mem3[a3 + 8'd2], mem3[a3 + 8'd3]};

    always @(posedge clk) begin
        if (bus1.mem_write) begin
            mem1[a1]        <= bus1.mem_wdata[31:24];
            mem1[a1 + 8'd1] <= bus1.mem_wdata[23:16];
            mem1[a1 + 8'd2] <= bus1.mem_wdata[15:8];
            mem1[a1 + 8'd3] <= bus1.mem_wdata[7:0];
        end
        if (bus3.mem_write) begin
            mem3[a3]        <= bus3.mem_wdata[31:24];
            mem3[a3 + 8'd1] <= bus3.mem_wdata[23:16];
            mem3[a3 + 8'd2] <= bus3.mem_wdata[15:8];
            mem3[a3 + 8'd3] <= bus3.mem_wdata[7:0];
        end
    end

    // One request on the MEM_LAT=1 instance; returns response and per-cycle memory activity
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output int rd_at, output int wr_at,
                          output logic both, output logic [31:0] maddr);
        rdata = 32'hBAD0BAD0; err = 1'bx; lat = -1;
        nrd = 0; nwr = 0; rd_at = -1; wr_at = -1; both = 1'b0; maddr = 32'hFFFFFFFF;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_size = size;
        bus1.req_signed = sgn; bus1.req_addr = addr; bus1.req_wdata = wdata;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus1.req_valid = 1'b0;
            if (bus1.mem_read) begin
                nrd++;
                if (rd_at < 0) begin rd_at = i; maddr = bus1.mem_addr; end
            end
            if (bus1.mem_write) begin
                nwr++;
                if (wr_at < 0) wr_at = i;
            end
            if (bus1.mem_read && bus1.mem_write) both = 1'b1;
            if (bus1.resp_valid) begin
                rdata = bus1.resp_rdata; err = bus1.resp_err; lat = i;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    logic        er;
    logic        bo;
    logic [31:0] ma;
    int          lt, nr, nw, ra, wa;

    task automatic test_reset();
        #1;
        vectors++; if (bus1.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", bus1.req_ready); end
        vectors++; if (bus1.resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid: got %b want 0", bus1.resp_valid); end
        vectors++; if ({bus1.mem_read, bus1.mem_write} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_mem_rw: got %b want 00", {bus1.mem_read, bus1.mem_write}); end
        vectors++; if (bus1.resp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h want 0", bus1.resp_rdata); end
        vectors++; if (bus1.resp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", bus1.resp_err); end
        vectors++; if ({bus1.mem_addr, bus1.mem_wdata} !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_addr_wdata: got %h want 0", {bus1.mem_addr, bus1.mem_wdata}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (lt !== 2) begin miscompares++; $display("[TB] FAIL wstore_latency: got %0d want 2", lt); end
        vectors++; if (nr !== 0 || nw !== 1) begin miscompares++; $display("[TB] FAIL wstore_access: got rd=%0d wr=%0d want rd=0 wr=1", nr, nw); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL wstore_rdata: got %h want 0", rd); end
        @(negedge clk);
        vectors++; if (bus1.resp_valid !== 1'b0 || bus1.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL resp_pulse: got valid=%b ready=%b want 0/1", bus1.resp_valid, bus1.req_ready); end
        vectors++; if ({mem1[8'h10], mem1[8'h11], mem1[8'h12], mem1[8'h13]} !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL dm_bytes: got %h want deadbeef", {mem1[8'h10], mem1[8'h11], mem1[8'h12], mem1[8'h13]}); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL wload_data: got %h want deadbeef", rd); end
        vectors++; if (lt !== 2) begin miscompares++; $display("[TB] FAIL wload_latency: got %0d want 2", lt); end
    endtask

    task automatic test_byte_store();
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'hAB_CD_EF_55, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (ra !== 1 || wa !== 2 || nr !== 1 || nw !== 1) begin miscompares++; $display("[TB] FAIL rmw_order: got rd_at=%0d wr_at=%0d nrd=%0d nwr=%0d want 1 2 1 1", ra, wa, nr, nw); end
        vectors++; if (bo !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_wr_overlap: got %b want 0", bo); end
        vectors++; if (lt !== 3) begin miscompares++; $display("[TB] FAIL bstore_latency: got %0d want 3", lt); end
        vectors++; if (ma !== 32'h10) begin miscompares++; $display("[TB] FAIL bstore_addr: got %h want 10", ma); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (rd !== 32'hDEAD55EF) begin miscompares++; $display("[TB] FAIL bstore_merge: got %h want dead55ef", rd); end
    endtask

    task automatic test_subword_load();
        logic [1:0]  sz [6];
        logic        sg [6];
        logic [31:0] ad [6];
        logic [31:0] ex [6];
        sz = '{SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF, SZ_BYTE};
        sg = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ad = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h10, 32'h13};
        ex = '{32'hFFFFFFAD, 32'h000000AD, 32'h000055EF, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFEF};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, sz[i], sg[i], ad[i], 32'h0, rd, er, lt, nr, nw, ra, wa, bo, ma);
            vectors++; if (rd !== ex[i]) begin miscompares++; $display("[TB] FAIL subload_%0d: got %h want %h", i, rd, ex[i]); end
        end
        vectors++; if (ma !== 32'h10) begin miscompares++; $display("[TB] FAIL subload_addr: got %h want 10", ma); end
    endtask

    task automatic test_misalign();
        do_req(1'b0, SZ_WORD, 1'b0, 32'h11, 32'h0, rd, er, lt, nr, nw, ra, wa, bo, ma);
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL misalign_trap: got err=%b rdata=%h want 1/0", er, rd); end
        vectors++; if (nr !== 0 || nw !== 0) begin miscompares++; $display("[TB] FAIL misalign_noaccess: got rd=%0d wr=%0d want 0 0", nr, nw); end
`else
        vectors++; if (er !== 1'b0 || rd !== 32'hDEAD55EF) begin miscompares++; $display("[TB] FAIL misalign_word: got err=%b rdata=%h want 0/dead55ef", er, rd); end
`endif
    endtask

    task automatic test_half_store();
        do_req(1'b1, SZ_HALF, 1'b0, 32'h10, 32'h00001234, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (lt !== 3) begin miscompares++; $display("[TB] FAIL hstore_latency: got %0d want 3", lt); end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lt, nr, nw, ra, wa, bo, ma);
        vectors++; if (rd !== 32'h123455EF) begin miscompares++; $display("[TB] FAIL hstore_merge: got %h want 123455ef", rd); end
    endtask

    task automatic test_mem_lat3();
        int nread, lat;
        logic ready_seen;
        logic [31:0] data;
        nread = 0; lat = -1; ready_seen = 1'b0; data = 32'hBAD0BAD0;
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_size = SZ_WORD;
        bus3.req_signed = 1'b0; bus3.req_addr = 32'h10;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus3.req_valid = 1'b0;
            if (bus3.mem_read) nread++;
            if (bus3.req_ready) ready_seen = 1'b1;
            if (bus3.resp_valid) begin lat = i; data = bus3.resp_rdata; break; end
        end
        vectors++; if (nread !== 3) begin miscompares++; $display("[TB] FAIL lat3_read_cycles: got %0d want 3", nread); end
        vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL lat3_latency: got %0d want 4", lat); end
        vectors++; if (ready_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL lat3_ready: got %b want 0", ready_seen); end
        vectors++; if (data !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL lat3_data: got %h want deadbeef", data); end
    endtask

    task automatic test_reset_abort();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_size = SZ_BYTE;
        bus1.req_addr = 32'h21; bus1.req_wdata = 32'h99;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        vectors++; if (bus1.mem_read !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_in_rd: got %b want 1", bus1.mem_read); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (bus1.mem_read !== 1'b0 || bus1.mem_write !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_immediate: got rd=%b wr=%b want 0 0", bus1.mem_read, bus1.mem_write); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (bus1.mem_write || bus1.resp_valid) bad = 1'b1;
        end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_activity: got %b want 0", bad); end
        vectors++; if (bus1.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready: got %b want 1", bus1.req_ready); end
        vectors++; if ({mem1[8'h20], mem1[8'h21], mem1[8'h22], mem1[8'h23]} !== 32'h11223344) begin miscompares++; $display("[TB] FAIL abort_dm: got %h want 11223344", {mem1[8'h20], mem1[8'h21], mem1[8'h22], mem1[8'h23]}); end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        {mem1[8'h20], mem1[8'h21], mem1[8'h22], mem1[8'h23]} = 32'h11223344;
        {mem3[8'h10], mem3[8'h11], mem3[8'h12], mem3[8'h13]} = 32'hDEADBEEF;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_size = 2'b00;
        bus1.req_signed = 1'b0; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_size = 2'b00;
        bus3.req_signed = 1'b0; bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0;
        #12;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_subword_load();
        test_misalign();
        test_half_store();
        test_mem_lat3();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
